// File: rtl/branch_global_predictor.sv
// ---------------------------------------------------------------------------
// branch_global_predictor
//   Global-history branch direction predictor. A pattern history table (PHT)
//   of 2-bit saturating counters is read combinationally in IF, indexed by the
//   global branch history register (BHR). The EX stage trains the counter
//   selected by the BHR snapshot that travelled with the branch, and shifts
//   the resolved outcome into the live BHR.
//
//   Optional feature macro: GSHARE_XOR_EN
//     defined   : index = history XOR pc[PC_LSB +: n]  (gshare)
//     undefined : index = history                     (pure global, PCs unused)
//
//   Reset is synchronous and active-high. Updates only happen at resolution,
//   so the BHR never holds speculative history and a flush needs no repair.
// ---------------------------------------------------------------------------
module branch_global_predictor #(
  parameter int N      = 128,  // PHT entries, power of two, at least 4
  parameter int PC_LSB = 2     // lowest PC bit folded into the gshare hash
) (
  input  logic                 clk,
  input  logic                 rst,
  // IF stage: prediction lookup
  input  logic [31:0]          pc_if,
  input  logic                 is_branch_if,
  output logic                 glob_predict_taken_if,
  output logic [$clog2(N)-1:0] bhr_if,
  // EX stage: training with the resolved outcome
  input  logic                 is_branch_ex,
  input  logic [31:0]          pc_ex,
  input  logic [$clog2(N)-1:0] bhr_ex,
  input  logic                 cmp_out_ex
);

  localparam int IDX_W = $clog2(N);

  // 2-bit counter encodings: strongly/weakly not-taken, weakly/strongly taken.
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  logic [1:0]       pht [N];
  logic [IDX_W-1:0] bhr;
  logic [IDX_W-1:0] idx_if;
  logic [IDX_W-1:0] idx_ex;

  // Saturating counter step: move one state toward the resolved direction,
  // holding at the strong end states.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr,
                                          input logic       taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != CTR_ST)  nxt = ctr + 2'b01;
    end else begin
      if (ctr != CTR_SNT) nxt = ctr - 2'b01;
    end
    return nxt;
  endfunction

  // Index formation for the IF lookup and the EX training write.
  // NOTE: every signal assigned in always_comb gets a value on every path, so
  // no latch is inferred.
  always_comb begin
`ifdef GSHARE_XOR_EN
    idx_if = bhr    ^ pc_if[PC_LSB +: IDX_W];
    idx_ex = bhr_ex ^ pc_ex[PC_LSB +: IDX_W];
`else
    idx_if = bhr;
    idx_ex = bhr_ex;
`endif
  end

`ifndef GSHARE_XOR_EN
  // The hash offset only matters for gshare indexing.
  localparam int unused_pc_lsb = PC_LSB;
`endif

  // is_branch_if never alters state: the lookup is valid every cycle and the
  // IF stage decides whether to use it. PC bits outside the hash slice (or
  // all of them in pure global mode) do not affect the predictor.
  logic unused_inputs;
  assign unused_inputs = ^{is_branch_if, pc_if, pc_ex};

  // Lookup: prediction is the counter MSB; the raw history leaves with the
  // branch so EX can train the same entry later. A same-cycle EX write to
  // this entry is not bypassed; IF sees the pre-update counter.
  assign glob_predict_taken_if = pht[idx_if][1];
  assign bhr_if                = bhr;

  // Reset to weakly-not-taken / empty history, otherwise train on resolution.
  // Reset wins over a same-cycle EX update, which is then dropped.
  // NOTE: the PHT is a register array, not a RAM macro, so all entries can be
  // cleared in the single reset cycle; state updates use non-blocking
  // assignments so every read in this block sees the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      bhr <= '0;
      for (int i = 0; i < N; i++) begin
        pht[i] <= CTR_WNT;
      end
    end else if (is_branch_ex) begin
      pht[idx_ex] <= ctr_next(pht[idx_ex], cmp_out_ex);
      // The live history shifts, independent of the snapshot used to index.
      bhr         <= {bhr[IDX_W-2:0], cmp_out_ex};
    end
  end

  // CTR_WT is named for completeness of the encoding; it is only reached by
  // arithmetic in ctr_next.
  logic [1:0] unused_ctr_wt;
  assign unused_ctr_wt = CTR_WT;

endmodule
